wbrrarb: RTL and testbench

Two-master, round-robin Wishbone (pipelined) arbiter that shares one wide downstream bus port between requesters A and B. Typical placement: ahead of the wide-to-narrow bus downconverter, so two bus masters (e.g. CPU data path and DMA) can share one narrow memory port. Ownership is held for a master's entire CYC. The block tracks outstanding requests and an optional watchdog, so a hung slave releases the bus with an error.

---
 rtl/wbrrarb_pkg.sv | 15 +
 rtl/wbrrarb.sv | 161 ++++++++++++++++
 tb/tb_wbrrarb.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbrrarb_pkg.sv
// Shared types for the two-master round-robin Wishbone arbiter.
package wbrrarb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } state_e;

  typedef enum logic {
    MST_A,
    MST_B
  } mst_e;

endpackage

// File: rtl/wbrrarb.sv
// Two-master round-robin pipelined Wishbone arbiter; ownership lasts a whole CYC,
// with outstanding-request limiting and an optional watchdog that aborts a hung slave.
module wbrrarb
  import wbrrarb_pkg::*;
#(
  parameter int AW       = 26,
  parameter int DW       = 64,
  parameter int LGMAXOUT = 5,
  parameter int TIMEOUT  = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  output logic [DW-1:0]   o_a_data,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_b_data,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_stall,
  input  logic            i_ack,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LGMAXOUT:0] NOUT_MAX = {1'b0, {LGMAXOUT{1'b1}}};
  localparam logic [LGMAXOUT:0] NOUT_ONE = (LGMAXOUT + 1)'(1);
  localparam logic [WDW-1:0]    WD_ONE   = WDW'(1);

  state_e            state_q;
  mst_e              last_q;
  logic [LGMAXOUT:0] nout_q, nout_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              abort_q, werr_q;

  logic            own_a, own_b, pass, full;
  logic            m_cyc, m_stb, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [DW/8-1:0] m_sel;
  logic            stall_m, ack_m, err_m;
  logic            a_req, b_req, inc, dec, wd_count, wd_expire;

  assign o_a_data = i_data;
  assign o_b_data = i_data;

  always_comb begin
    own_a = (state_q == OWN_A);
    own_b = (state_q == OWN_B);
    a_req = i_a_cyc && i_a_stb;
    b_req = i_b_cyc && i_b_stb;
    full  = (nout_q == NOUT_MAX);
    pass  = (own_a || own_b) && !abort_q;

    m_cyc  = own_b ? i_b_cyc  : i_a_cyc;
    m_stb  = own_b ? i_b_stb  : i_a_stb;
    m_we   = own_b ? i_b_we   : i_a_we;
    m_addr = own_b ? i_b_addr : i_a_addr;
    m_data = own_b ? i_b_data : i_a_data;
    m_sel  = own_b ? i_b_sel  : i_a_sel;

    // Downstream fields are zeroed whenever nothing is passed through, so reset reads 0.
    o_cyc  = pass && m_cyc;
    o_stb  = pass && m_cyc && m_stb && !full;
    o_we   = pass && m_we;
    o_addr = pass ? m_addr : '0;
    o_data = pass ? m_data : '0;
    o_sel  = pass ? m_sel  : '0;

    stall_m = !pass || i_stall || full;
    ack_m   = pass && m_cyc && i_ack;
    err_m   = (pass && m_cyc && i_err) || werr_q;

    o_a_stall = own_a ? stall_m : 1'b1;
    o_b_stall = own_b ? stall_m : 1'b1;
    o_a_ack   = own_a && ack_m;
    o_b_ack   = own_b && ack_m;
    o_a_err   = own_a && err_m;
    o_b_err   = own_b && err_m;

    inc    = o_stb && !i_stall;
    dec    = i_ack && (nout_q != '0);
    nout_d = nout_q;
    if (inc && !dec)
      nout_d = nout_q + NOUT_ONE;
    else if (dec && !inc)
      nout_d = nout_q - NOUT_ONE;

    wd_count  = (TIMEOUT > 0) && (nout_q != '0) && !i_ack;
    wdog_d    = wd_count ? (wdog_q + WD_ONE) : '0;
    wd_expire = wd_count && ((int'(wdog_q) + 1) >= (TIMEOUT - 1));
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= MST_B;
      nout_q  <= '0;
      wdog_q  <= '0;
      abort_q <= 1'b0;
      werr_q  <= 1'b0;
    end else begin
      werr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          nout_q  <= '0;
          wdog_q  <= '0;
          abort_q <= 1'b0;
          if (a_req && (!b_req || last_q == MST_B)) begin
            state_q <= OWN_A;
            last_q  <= MST_A;
          end else if (b_req) begin
            state_q <= OWN_B;
            last_q  <= MST_B;
          end
        end
        default: begin
          if (!m_cyc) begin
            state_q <= IDLE;
            nout_q  <= '0;
            wdog_q  <= '0;
            abort_q <= 1'b0;
          end else if (abort_q) begin
            nout_q <= '0;
            wdog_q <= '0;
          end else if (i_err || wd_expire) begin
            // A slave error is reported combinationally; only expiry needs the registered err.
            abort_q <= 1'b1;
            werr_q  <= wd_expire && !i_err;
            nout_q  <= '0;
            wdog_q  <= '0;
          end else begin
            nout_q <= nout_d;
            wdog_q <= wdog_d;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbrrarb.sv
// Scoreboard bench for wbrrarb: directed master/slave vectors push expected
// downstream requests and master responses; a negedge monitor pops and compares.
module tb_wbrrarb;

  localparam int AW       = 26;
  localparam int DW       = 64;
  localparam int LGMAXOUT = 2;
  localparam int TIMEOUT  = 8;
  localparam logic [DW/8-1:0] SEL_A = 8'hFF;
  localparam logic [DW/8-1:0] SEL_B = 8'h3C;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0]   i_a_addr;
  logic [DW-1:0]   i_a_data;
  logic [DW/8-1:0] i_a_sel;
  logic            o_a_stall, o_a_ack, o_a_err;
  logic [DW-1:0]   o_a_data;
  logic            i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0]   i_b_addr;
  logic [DW-1:0]   i_b_data;
  logic [DW/8-1:0] i_b_sel;
  logic            o_b_stall, o_b_ack, o_b_err;
  logic [DW-1:0]   o_b_data;
  logic            o_cyc, o_stb, o_we;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_data;
  logic [DW/8-1:0] o_sel;
  logic            i_stall, i_ack, i_err;
  logic [DW-1:0]   i_data;

  wbrrarb #(.AW(AW), .DW(DW), .LGMAXOUT(LGMAXOUT), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err), .o_a_data(o_a_data),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err), .o_b_data(o_b_data),
    .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_data(o_data),
    .o_sel(o_sel), .i_stall(i_stall), .i_ack(i_ack), .i_err(i_err), .i_data(i_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
    logic [DW/8-1:0] sel;
  } req_t;

  typedef struct {
    logic          m;
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  req_t dq[$];
  rsp_t rq[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  function automatic logic [DW-1:0] wdat(input logic [AW-1:0] a);
    return {8'hA5, 30'h0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic exp_req(input logic we, input logic [AW-1:0] addr, input logic [DW/8-1:0] sel);
    req_t e;
    e.we = we; e.addr = addr; e.data = wdat(addr); e.sel = sel;
    dq.push_back(e);
  endtask

  task automatic exp_rsp(input logic m, input logic err, input logic [DW-1:0] data);
    rsp_t r;
    r.m = m; r.err = err; r.data = data;
    rq.push_back(r);
  endtask

  task automatic mon_rsp(input logic m, input logic err, input logic [DW-1:0] data);
    rsp_t r;
    if (rq.size() == 0) begin
      n_chk++;
      $display("FAIL rsp_unexpected: got master=%0d err=%0d, none expected", m, err);
    end else begin
      r = rq.pop_front();
      chk("rsp_master", {63'h0, m}, {63'h0, r.m});
      chk("rsp_err", {63'h0, err}, {63'h0, r.err});
      if (!r.err) chk("rsp_data", data, r.data);
    end
  endtask

  always @(negedge i_clk) begin
    req_t e;
    if (o_cyc && o_stb && !i_stall) begin
      if (dq.size() == 0) begin
        n_chk++;
        $display("FAIL req_unexpected: got addr %0h, none expected", o_addr);
      end else begin
        e = dq.pop_front();
        chk("req_addr", 64'(o_addr), 64'(e.addr));
        chk("req_we", {63'h0, o_we}, {63'h0, e.we});
        chk("req_sel", 64'(o_sel), 64'(e.sel));
        if (e.we) chk("req_data", o_data, e.data);
      end
    end
    if (o_a_ack || o_a_err) mon_rsp(1'b0, o_a_err, o_a_data);
    if (o_b_ack || o_b_err) mon_rsp(1'b1, o_b_err, o_b_data);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv_a(input logic cyc, input logic stb, input logic we, input logic [AW-1:0] addr);
    i_a_cyc = cyc; i_a_stb = stb; i_a_we = we; i_a_addr = addr;
    i_a_data = wdat(addr); i_a_sel = SEL_A;
  endtask

  task automatic drv_b(input logic cyc, input logic stb, input logic we, input logic [AW-1:0] addr);
    i_b_cyc = cyc; i_b_stb = stb; i_b_we = we; i_b_addr = addr;
    i_b_data = wdat(addr); i_b_sel = SEL_B;
  endtask

  task automatic slave_ack(input logic m, input logic [DW-1:0] data);
    i_ack = 1'b1; i_data = data;
    exp_rsp(m, 1'b0, data);
  endtask

  task automatic idle_all();
    drv_a(1'b0, 1'b0, 1'b0, '0);
    drv_b(1'b0, 1'b0, 1'b0, '0);
    i_stall = 1'b0; i_ack = 1'b0; i_err = 1'b0; i_data = '0;
  endtask

  task automatic do_reset();
    idle_all();
    @(posedge i_clk);
    #3 i_reset = 1'b1;
    @(posedge i_clk);
    #3 i_reset = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cyc"}, {63'h0, o_cyc}, 64'h0);
    chk({tag, "_stb"}, {63'h0, o_stb}, 64'h0);
    chk({tag, "_acks"}, {62'h0, o_a_ack, o_b_ack}, 64'h0);
    chk({tag, "_errs"}, {62'h0, o_a_err, o_b_err}, 64'h0);
    chk({tag, "_stalls"}, {62'h0, o_a_stall, o_b_stall}, 64'h3);
    chk({tag, "_addr"}, 64'(o_addr), 64'h0);
    chk({tag, "_we_sel"}, {55'h0, o_we, o_sel}, 64'h0);
    chk({tag, "_data"}, o_data, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b0;
    idle_all();
    #1 i_reset = 1'b1;
    #1 chk_reset_outs("reset");
    #6 i_reset = 1'b0;

    // A alone: four writes, acks one cycle behind
    tick(); drv_a(1, 1, 1, 26'h10); settle();
    chk("t1_idle_cyc", {63'h0, o_cyc}, 64'h0);
    chk("t1_idle_astall", {63'h0, o_a_stall}, 64'h1);
    for (int i = 0; i < 4; i++) exp_req(1'b1, AW'(32'h10 + i), SEL_A);
    for (int i = 0; i < 4; i++) begin
      tick(); drv_a(1, 1, 1, AW'(32'h10 + i));
      if (i > 0) slave_ack(1'b0, 64'h1000 + 64'(i - 1)); else i_ack = 1'b0;
      settle();
      chk("t1_astall", {63'h0, o_a_stall}, 64'h0);
      chk("t1_bstall", {63'h0, o_b_stall}, 64'h1);
    end
    tick(); drv_a(1, 0, 1, 26'h13); slave_ack(1'b0, 64'h1003); settle();
    chk("t1_bstall_end", {63'h0, o_b_stall}, 64'h1);
    tick(); drv_a(0, 0, 0, '0); i_ack = 1'b0; settle();
    chk("t1_drop_cyc", {63'h0, o_cyc}, 64'h0);

    // Simultaneous requests: A first, idle gap, then B, then A again
    do_reset();
    tick(); drv_a(1, 1, 0, 26'h20); drv_b(1, 1, 0, 26'h30); settle();
    chk("t2_idle_cyc", {63'h0, o_cyc}, 64'h0);
    exp_req(1'b0, 26'h20, SEL_A);
    tick(); settle();
    chk("t2_grant_a_astall", {63'h0, o_a_stall}, 64'h0);
    chk("t2_grant_a_bstall", {63'h0, o_b_stall}, 64'h1);
    tick(); drv_a(1, 0, 0, 26'h20); slave_ack(1'b0, 64'h2000); settle();
    tick(); drv_a(0, 0, 0, '0); i_ack = 1'b0; settle();
    chk("t2_a_drop_cyc", {63'h0, o_cyc}, 64'h0);
    tick(); settle();
    chk("t2_gap_cyc", {63'h0, o_cyc}, 64'h0);
    chk("t2_gap_bstall", {63'h0, o_b_stall}, 64'h1);
    exp_req(1'b0, 26'h30, SEL_B);
    tick(); settle();
    chk("t2_grant_b_cyc", {63'h0, o_cyc}, 64'h1);
    chk("t2_grant_b_bstall", {63'h0, o_b_stall}, 64'h0);
    tick(); drv_b(1, 0, 0, 26'h30); slave_ack(1'b1, 64'h3000); settle();
    tick(); drv_b(0, 0, 0, '0); i_ack = 1'b0; settle();
    tick(); drv_a(1, 1, 0, 26'h21); drv_b(1, 1, 0, 26'h31); settle();
    exp_req(1'b0, 26'h21, SEL_A);
    tick(); settle();
    chk("t2_alt_astall", {63'h0, o_a_stall}, 64'h0);
    chk("t2_alt_bstall", {63'h0, o_b_stall}, 64'h1);
    tick(); drv_a(1, 0, 0, 26'h21); drv_b(0, 0, 0, '0); slave_ack(1'b0, 64'h2100); settle();
    tick(); drv_a(0, 0, 0, '0); i_ack = 1'b0; settle();

    // Back-pressure: three in flight fill the pipe
    do_reset();
    tick(); drv_a(1, 1, 0, 26'h40); settle();
    for (int i = 0; i < 3; i++) exp_req(1'b0, AW'(32'h40 + i), SEL_A);
    for (int i = 0; i < 3; i++) begin
      tick(); drv_a(1, 1, 0, AW'(32'h40 + i)); settle();
      chk("t3_accept_stall", {63'h0, o_a_stall}, 64'h0);
    end
    tick(); drv_a(1, 1, 0, 26'h43); settle();
    chk("t3_full_stall", {63'h0, o_a_stall}, 64'h1);
    chk("t3_full_stb", {63'h0, o_stb}, 64'h0);
    tick(); slave_ack(1'b0, 64'h4000); settle();
    chk("t3_full_ack_stall", {63'h0, o_a_stall}, 64'h1);
    exp_req(1'b0, 26'h43, SEL_A);
    tick(); slave_ack(1'b0, 64'h4001); settle();
    chk("t3_ackreq_stall", {63'h0, o_a_stall}, 64'h0);
    exp_req(1'b0, 26'h44, SEL_A);
    tick(); drv_a(1, 1, 0, 26'h44); i_ack = 1'b0; settle();
    chk("t3_refill_stall", {63'h0, o_a_stall}, 64'h0);
    tick(); drv_a(1, 1, 0, 26'h45); settle();
    chk("t3_refull_stall", {63'h0, o_a_stall}, 64'h1);
    tick(); drv_a(0, 0, 0, '0); settle();

    // Slave error on the second of three reads
    do_reset();
    tick(); drv_a(1, 1, 0, 26'h50); settle();
    for (int i = 0; i < 3; i++) exp_req(1'b0, AW'(32'h50 + i), SEL_A);
    tick(); settle();
    tick(); drv_a(1, 1, 0, 26'h51); slave_ack(1'b0, 64'h5000); settle();
    tick(); drv_a(1, 1, 0, 26'h52); i_ack = 1'b0; i_err = 1'b1; exp_rsp(1'b0, 1'b1, '0); settle();
    chk("t4_err_cyc", {63'h0, o_cyc}, 64'h1);
    tick(); drv_a(1, 0, 0, 26'h52); drv_b(1, 1, 0, 26'h60); i_err = 1'b0;
    i_ack = 1'b1; i_data = 64'h5200; settle();
    chk("t4_abort_cyc", {63'h0, o_cyc}, 64'h0);
    chk("t4_abort_stb", {63'h0, o_stb}, 64'h0);
    chk("t4_abort_astall", {63'h0, o_a_stall}, 64'h1);
    chk("t4_abort_aack", {63'h0, o_a_ack}, 64'h0);
    chk("t4_abort_bstall", {63'h0, o_b_stall}, 64'h1);
    tick(); i_ack = 1'b0; settle();
    chk("t4_hold_cyc", {63'h0, o_cyc}, 64'h0);
    tick(); drv_a(0, 0, 0, '0); settle();
    chk("t4_drop_bstall", {63'h0, o_b_stall}, 64'h1);
    tick(); settle();
    chk("t4_idle_cyc", {63'h0, o_cyc}, 64'h0);
    exp_req(1'b0, 26'h60, SEL_B);
    tick(); settle();
    chk("t4_grant_b_cyc", {63'h0, o_cyc}, 64'h1);
    tick(); drv_b(1, 0, 0, 26'h60); slave_ack(1'b1, 64'h6000); settle();
    tick(); drv_b(0, 0, 0, '0); i_ack = 1'b0; settle();

    // Watchdog: no ack ever returns
    do_reset();
    tick(); drv_a(1, 1, 0, 26'h70); settle();
    exp_req(1'b0, 26'h70, SEL_A);
    tick(); settle();
    for (int i = 2; i <= 8; i++) begin
      tick(); drv_a(1, 0, 0, 26'h70); settle();
      chk("t5_wait_cyc", {63'h0, o_cyc}, 64'h1);
      chk("t5_wait_err", {63'h0, o_a_err}, 64'h0);
    end
    exp_rsp(1'b0, 1'b1, '0);
    tick(); settle();
    chk("t5_timeout_err", {63'h0, o_a_err}, 64'h1);
    chk("t5_timeout_cyc", {63'h0, o_cyc}, 64'h0);
    tick(); settle();
    chk("t5_err_once", {63'h0, o_a_err}, 64'h0);
    chk("t5_abort_stall", {63'h0, o_a_stall}, 64'h1);
    tick(); drv_a(0, 0, 0, '0); settle();

    // Asynchronous reset in the middle of an A burst
    do_reset();
    tick(); drv_a(1, 1, 1, 26'h80); settle();
    exp_req(1'b1, 26'h80, SEL_A);
    tick(); settle();
    tick(); drv_a(1, 1, 1, 26'h81); i_ack = 1'b1; i_data = 64'h8000; settle();
    chk("t6_pre_cyc", {63'h0, o_cyc}, 64'h1);
    #1 i_reset = 1'b1;
    #1 chk_reset_outs("t6_async");
    tick(); drv_a(1, 1, 0, 26'h82); drv_b(1, 1, 0, 26'h90); i_ack = 1'b0; settle();
    chk("t6_held_cyc", {63'h0, o_cyc}, 64'h0);
    #2 i_reset = 1'b0;
    exp_req(1'b0, 26'h82, SEL_A);
    tick(); settle();
    chk("t6_grant_astall", {63'h0, o_a_stall}, 64'h0);
    chk("t6_grant_bstall", {63'h0, o_b_stall}, 64'h1);
    tick(); drv_a(1, 0, 0, 26'h82); drv_b(0, 0, 0, '0); slave_ack(1'b0, 64'h8200); settle();
    tick(); drv_a(0, 0, 0, '0); i_ack = 1'b0; settle();
    tick(); settle();

    chk("req_queue_drained", 64'(dq.size()), 64'h0);
    chk("rsp_queue_drained", 64'(rq.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
